// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the sequential radix-2 FFT stage:
// saturation, butterfly pair/twiddle index mapping and twiddle ROM generation.
package fft_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} stage_state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               clip;
  } sat_t;

  typedef struct packed {
    int top;
    int bot;
    int tw;
  } pair_idx_t;

  localparam real PI = 3.14159265358979323846;

  // Clamp a wide signed value into a signed field of `width` bits.
  function automatic sat_t sat_round(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    r.clip = 1'b1;
    if (value > hi)      r.value = hi;
    else if (value < lo) r.value = lo;
    else begin
      r.value = value;
      r.clip  = 1'b0;
    end
    return r;
  endfunction

  function automatic pair_idx_t pair_map(input int p, input int span, input int n);
    pair_idx_t r;
    r.top = (p / span) * 2 * span + (p % span);
    r.bot = r.top + span;
    r.tw  = (p % span) * (n / (2 * span));
    return r;
  endfunction

  // W^t = cos(2*pi*t/n) - j*sin(2*pi*t/n), rounded half away from zero, then saturated.
  function automatic logic signed [63:0] twiddle(input int t, input int n, input int frac,
                                                 input int dw, input bit imag);
    real    ang;
    real    v;
    real    r;
    longint q;
    ang = 2.0 * PI * real'(t) / real'(n);
    v   = (imag ? -$sin(ang) : $cos(ang)) * real'(longint'(1) << frac);
    r   = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    q   = longint'(r);
    return sat_round(q, dw).value;
  endfunction

endpackage

// File: rtl/fft_bfly_unit.sv
// One combinational radix-2 DIT butterfly: b*W with rounding, a +/- product,
// optional halving and saturation of every output word.
module fft_bfly_unit
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRACTION   = 4
) (
  input  logic [2*DATA_WIDTH-1:0] a,
  input  logic [2*DATA_WIDTH-1:0] b,
  input  logic [2*DATA_WIDTH-1:0] w,
  input  logic                    scale_en,
  output logic [2*DATA_WIDTH-1:0] top,
  output logic [2*DATA_WIDTH-1:0] bot,
  output logic                    overflow
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2*DW + 1;
  localparam logic signed [PW-1:0]   RND = PW'(1) <<< (FRACTION - 1);
  localparam logic signed [DW+1:0]   ONE = (DW+2)'(1);

  logic signed [PW-1:0] br, bi, wr, wi;
  logic signed [PW-1:0] prod_re, prod_im, rnd_re, rnd_im;
  logic signed [DW+1:0] ar, ai, pr, pi;
  logic signed [DW+1:0] pre [4];
  logic signed [DW+1:0] sc  [4];
  logic [DW-1:0]        post [4];
  logic [3:0]           clip;

  assign br = PW'($signed(b[DW-1:0]));
  assign bi = PW'($signed(b[2*DW-1:DW]));
  assign wr = PW'($signed(w[DW-1:0]));
  assign wi = PW'($signed(w[2*DW-1:DW]));
  assign ar = (DW+2)'($signed(a[DW-1:0]));
  assign ai = (DW+2)'($signed(a[2*DW-1:DW]));

  assign prod_re = br * wr - bi * wi;
  assign prod_im = br * wi + bi * wr;
  assign rnd_re  = (prod_re + RND) >>> FRACTION;
  assign rnd_im  = (prod_im + RND) >>> FRACTION;

  // |b*W| stays below 2^DW, so the rounded product always fits DW+2 bits.
  assign pr = $signed(rnd_re[DW+1:0]);
  assign pi = $signed(rnd_im[DW+1:0]);

  assign pre[0] = ar + pr;
  assign pre[1] = ai + pi;
  assign pre[2] = ar - pr;
  assign pre[3] = ai - pi;

  // NOTE: every variable driven here is assigned on every pass, so no latch is inferred.
  always_comb begin
    clip = '0;
    for (int k = 0; k < 4; k++) begin
      sc[k]   = scale_en ? (pre[k] + ONE) >>> 1 : pre[k];
      post[k] = sat_round(64'(sc[k]), DW).value[DW-1:0];
      clip[k] = sat_round(64'(sc[k]), DW).clip;
    end
  end

  assign top      = {post[1], post[0]};
  assign bot      = {post[3], post[2]};
  assign overflow = |clip;

endmodule

// File: rtl/fft_r2_stage_seq.sv
// Sequential radix-2 FFT stage: latches a frame, runs NUM_BFLY butterflies over it
// in place for N/(2*NUM_BFLY) cycles, then presents the result with valid/ready.
module fft_r2_stage_seq
  import fft_pkg::*;
#(
  parameter int N          = 32,
  parameter int SPAN       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FRACTION   = 4,
  parameter int NUM_BFLY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scale_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*2*DATA_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*2*DATA_WIDTH-1:0] out_data,
  output logic                      overflow,
  output logic                      busy
);
  localparam int DW    = DATA_WIDTH;
  localparam int C     = N / (2 * NUM_BFLY);
  localparam int CNT_W = $clog2(C + 1);
  localparam int IDX_W = $clog2(N);

  typedef struct packed {
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] re;
  } cplx_t;

  stage_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              scale_q;
  logic              commit;
  cplx_t             bank    [N];
  cplx_t             tw_rom  [N/2];
  cplx_t             a_op    [NUM_BFLY];
  cplx_t             b_op    [NUM_BFLY];
  cplx_t             w_op    [NUM_BFLY];
  cplx_t             res_top [NUM_BFLY];
  cplx_t             res_bot [NUM_BFLY];
  logic [IDX_W-1:0]  top_idx [NUM_BFLY];
  logic [IDX_W-1:0]  bot_idx [NUM_BFLY];
  logic [NUM_BFLY-1:0] bfly_ovf;
  pair_idx_t         pm;

  for (genvar t = 0; t < N/2; t++) begin : g_tw
    localparam logic signed [63:0] WR = twiddle(t, N, FRACTION, DW, 1'b0);
    localparam logic signed [63:0] WI = twiddle(t, N, FRACTION, DW, 1'b1);
    assign tw_rom[t] = {WI[DW-1:0], WR[DW-1:0]};
  end

  // Count C is the extra cycle that copies the finished bank to out_data.
  assign commit = (cnt_q == CNT_W'(C));

  always_comb begin
    pm = '0;
    for (int u = 0; u < NUM_BFLY; u++) begin
      pm         = pair_map(int'(cnt_q) * NUM_BFLY + u, SPAN, N);
      top_idx[u] = pm.top[IDX_W-1:0];
      bot_idx[u] = pm.bot[IDX_W-1:0];
      w_op[u]    = tw_rom[pm.tw[IDX_W-2:0]];
      a_op[u]    = bank[top_idx[u]];
      b_op[u]    = bank[bot_idx[u]];
    end
  end

  for (genvar u = 0; u < NUM_BFLY; u++) begin : g_bfly
    fft_bfly_unit #(
      .DATA_WIDTH (DW),
      .FRACTION   (FRACTION)
    ) u_bfly (
      .a        (a_op[u]),
      .b        (b_op[u]),
      .w        (w_op[u]),
      .scale_en (scale_q),
      .top      (res_top[u]),
      .bot      (res_bot[u]),
      .overflow (bfly_ovf[u])
    );
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (commit) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      scale_q  <= 1'b0;
      overflow <= 1'b0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: if (in_valid) begin
          scale_q  <= scale_en;
          overflow <= 1'b0;
          cnt_q    <= '0;
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (commit) begin
            for (int k = 0; k < N; k++) out_data[k*2*DW +: 2*DW] <= bank[k];
          end else begin
            overflow <= overflow | (|bfly_ovf);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the frame bank is datapath storage and is not reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      for (int k = 0; k < N; k++) bank[k] <= in_data[k*2*DW +: 2*DW];
    end else if (state_q == ST_CALC && !commit) begin
      for (int u = 0; u < NUM_BFLY; u++) begin
        bank[top_idx[u]] <= res_top[u];
        bank[bot_idx[u]] <= res_bot[u];
      end
    end
  end

endmodule

// File: tb/tb_fft_r2_stage_seq.sv
// Directed bench for fft_r2_stage_seq: default 32-point/span-8 instance plus a
// 16-point/span-1 variant, with hand-computed expected frames.
module tb_fft_r2_stage_seq;
  localparam int DW = 8;
  localparam int NA = 32;
  localparam int FA = NA * 2 * DW;
  localparam int NB = 16;
  localparam int FB = NB * 2 * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_scale, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
  logic [FA-1:0] a_in_data, a_out_data;
  logic          b_scale, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
  logic [FB-1:0] b_in_data, b_out_data;

  fft_r2_stage_seq dut_a (
    .clk       (clk),
    .reset     (reset),
    .scale_en  (a_scale),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .overflow  (a_ovf),
    .busy      (a_busy)
  );

  fft_r2_stage_seq #(
    .N(NB), .SPAN(1), .DATA_WIDTH(DW), .FRACTION(4), .NUM_BFLY(8)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .scale_en  (b_scale),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .overflow  (b_ovf),
    .busy      (b_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [FA-1:0] put(input logic [FA-1:0] f, input int k,
                                        input logic [7:0] re, input logic [7:0] im);
    logic [FA-1:0] r;
    r = f;
    r[k*16 +: 8]     = re;
    r[k*16 + 8 +: 8] = im;
    return r;
  endfunction

  function automatic int word_diffs(input logic [FA-1:0] got, input logic [FA-1:0] exp);
    int d;
    d = 0;
    for (int k = 0; k < 2*NA; k++) if (got[k*8 +: 8] !== exp[k*8 +: 8]) d++;
    return d;
  endfunction

  function automatic logic [7:0] word(input logic [FA-1:0] f, input int idx);
    return f[idx*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [FA-1:0] d, input logic sc);
    int guard;
    guard = 0;
    while (!a_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("send_in_ready", 64'(a_in_ready), 64'(1));
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_scale    = sc;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(output int edges);
    edges = 0;
    while (!a_out_valid && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  initial begin
    logic [FA-1:0] f_imp, e_imp, f_w2, e_w2, f_sat, e_sat0, e_sat1;
    logic [FB-1:0] fb, eb;
    int lat, bad, edges;

    reset = 1'b1;
    a_scale = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_scale = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_in_ready",  64'(a_in_ready),  64'(1));
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_busy",      64'(a_busy),      64'(0));
    check("rst_overflow",  64'(a_ovf),       64'(0));
    check("rst_out_data_zero", 64'(a_out_data == '0), 64'(1));
    check("rst_b_in_ready", 64'(b_in_ready), 64'(1));

    f_imp = '0;  f_imp = put(f_imp, 0, 8'h10, 8'h00);
    e_imp = '0;  e_imp = put(e_imp, 0, 8'h10, 8'h00); e_imp = put(e_imp, 8, 8'h10, 8'h00);
    f_w2  = '0;  f_w2  = put(f_w2, 9, 8'h10, 8'h00);
    e_w2  = '0;  e_w2  = put(e_w2, 1, 8'h0F, 8'hFA); e_w2 = put(e_w2, 9, 8'hF1, 8'h06);
    f_sat = '0;  f_sat = put(f_sat, 0, 8'h70, 8'h00); f_sat = put(f_sat, 8, 8'h70, 8'h00);
    e_sat0 = '0; e_sat0 = put(e_sat0, 0, 8'h7F, 8'h00);
    e_sat1 = '0; e_sat1 = put(e_sat1, 0, 8'h70, 8'h00);

    // Impulse
    send_a(f_imp, 1'b0);
    check("impulse_busy_calc", 64'(a_busy), 64'(1));
    check("impulse_in_ready_calc", 64'(a_in_ready), 64'(0));
    wait_a(lat);
    check("impulse_latency", 64'(lat), 64'(5));
    check("impulse_out0_re", 64'(word(a_out_data, 0)),  64'(8'h10));
    check("impulse_out8_re", 64'(word(a_out_data, 16)), 64'(8'h10));
    check("impulse_frame_diffs", 64'(word_diffs(a_out_data, e_imp)), 64'(0));
    check("impulse_overflow", 64'(a_ovf), 64'(0));
    release_a();
    check("impulse_in_ready_after", 64'(a_in_ready), 64'(1));
    check("impulse_out_valid_after", 64'(a_out_valid), 64'(0));

    // Twiddle W^2
    send_a(f_w2, 1'b0);
    wait_a(lat);
    check("w2_out1_re", 64'(word(a_out_data, 2)),  64'(8'h0F));
    check("w2_out1_im", 64'(word(a_out_data, 3)),  64'(8'hFA));
    check("w2_out9_re", 64'(word(a_out_data, 18)), 64'(8'hF1));
    check("w2_out9_im", 64'(word(a_out_data, 19)), 64'(8'h06));
    check("w2_frame_diffs", 64'(word_diffs(a_out_data, e_w2)), 64'(0));
    release_a();

    // Saturation, unscaled then scaled
    send_a(f_sat, 1'b0);
    wait_a(lat);
    check("sat_out0_re", 64'(word(a_out_data, 0)),  64'(8'h7F));
    check("sat_out8_re", 64'(word(a_out_data, 16)), 64'(8'h00));
    check("sat_frame_diffs", 64'(word_diffs(a_out_data, e_sat0)), 64'(0));
    check("sat_overflow", 64'(a_ovf), 64'(1));
    release_a();
    send_a(f_sat, 1'b1);
    wait_a(lat);
    check("sat_scaled_out0_re", 64'(word(a_out_data, 0)),  64'(8'h70));
    check("sat_scaled_out8_re", 64'(word(a_out_data, 16)), 64'(8'h00));
    check("sat_scaled_frame_diffs", 64'(word_diffs(a_out_data, e_sat1)), 64'(0));
    check("sat_scaled_overflow", 64'(a_ovf), 64'(0));
    release_a();

    // Backpressure: hold the W^2 result for 10 cycles while a second frame is offered
    send_a(f_w2, 1'b0);
    wait_a(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a_in_valid = 1'b1;
        a_in_data  = f_imp;
        a_scale    = 1'b0;
      end
      tick();
      bad += int'(word_diffs(a_out_data, e_w2) != 0) + int'(a_ovf) + int'(a_in_ready)
           + int'(!a_out_valid);
    end
    check("bp_hold_violations", 64'(bad), 64'(0));
    release_a();
    check("bp_in_ready_next", 64'(a_in_ready), 64'(1));
    tick();
    a_in_valid = 1'b0;
    wait_a(lat);
    check("bp_second_latency", 64'(lat), 64'(5));
    check("bp_second_frame_diffs", 64'(word_diffs(a_out_data, e_imp)), 64'(0));
    release_a();

    // Reset while the counter is at 2
    send_a(f_sat, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready",  64'(a_in_ready),  64'(1));
    check("midrst_out_valid", 64'(a_out_valid), 64'(0));
    check("midrst_busy",      64'(a_busy),      64'(0));
    check("midrst_out_data_zero", 64'(a_out_data == '0), 64'(1));
    check("midrst_overflow",  64'(a_ovf),       64'(0));
    reset = 1'b0;
    send_a(f_imp, 1'b0);
    wait_a(lat);
    check("midrst_next_latency", 64'(lat), 64'(5));
    check("midrst_next_frame_diffs", 64'(word_diffs(a_out_data, e_imp)), 64'(0));
    release_a();

    // 16-point, span-1, 8-unit variant
    fb = '0; fb[7:0] = 8'h10; fb[23:16] = 8'h10;
    eb = '0; eb[7:0] = 8'h20;
    check("var_in_ready", 64'(b_in_ready), 64'(1));
    b_in_valid = 1'b1;
    b_in_data  = fb;
    b_scale    = 1'b0;
    tick();
    b_in_valid = 1'b0;
    edges = 0;
    while (!b_out_valid && edges < 50) begin
      tick();
      edges++;
    end
    check("var_latency", 64'(edges), 64'(2));
    check("var_out0_re", 64'(b_out_data[7:0]),   64'(8'h20));
    check("var_out1_re", 64'(b_out_data[23:16]), 64'(8'h00));
    check("var_frame_match", 64'(b_out_data == eb), 64'(1));
    check("var_overflow", 64'(b_ovf), 64'(0));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check("var_in_ready_after", 64'(b_in_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_r2_stage_seq.md
Name: fft_r2_stage_seq

Overview:
- Parametrised radix-2 DIT butterfly stage for the pipelined FFT. Generalises the fixed 32-point/span-8 stage: any power-of-two N, any span, internal twiddle ROM, selectable 1/2 scaling.
- Accepts one full frame per valid/ready handshake into a register bank. Processes it time-multiplexed on NUM_BFLY butterfly units, then presents the result frame with valid/ready.
- Sits between consecutive FFT stages; chaining instances with SPAN = N/2, N/4 … 1 builds a complete FFT.

Parameters:
- N, 32: points per frame; power of two, ≥ 4.
- SPAN, 8: butterfly distance; power of two, < N.
- DATA_WIDTH, 8: signed two's-complement width of each real/imag word.
- FRACTION, 4: fractional bits; INTEGER = DATA_WIDTH − FRACTION, and INTEGER ≥ 2 so that +1.0 is representable.
- NUM_BFLY, 4: butterfly units; power of two, divides N/2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- scale_en  in  1  halve butterfly outputs; sampled at input handshake.
- in_valid  in  1  input frame valid.
- in_ready  out  1  stage can accept a frame.
- in_data  in  N*2*DATA_WIDTH  element k: real at [(2k)*DW +: DW], imag at [(2k+1)*DW +: DW].
- out_valid  out  1  result frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_data  out  N*2*DATA_WIDTH  result frame; same packing as in_data.
- overflow  out  1  sticky per frame; set if any saturation occurred.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (synchronous): state = IDLE; in_ready = 1; out_valid = 0; busy = 0; out_data = 0; overflow = 0; cycle counter = 0. Reset asserted mid-CALC or mid-DONE aborts the frame; the next cycle shows exactly the reset values.
- FSM:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_data and scale_en, clear overflow, go to CALC.
  - CALC: in_ready = 0. Runs C = N/(2*NUM_BFLY) cycles, counter 0..C−1; in cycle c, unit u processes pair p = c*NUM_BFLY + u. Go to DONE after cycle C−1.
  - DONE: out_valid = 1; out_data and overflow held stable. On out_valid & out_ready, go to IDLE.
- Timing:
  - in_ready returns to 1 the cycle after the output handshake.
  - in_valid is ignored outside IDLE.
  - out_valid rises C+1 clock edges after the input handshake edge (defaults: C = 4, edge 5).
- Pair mapping:
  - top i = (p / SPAN)*2*SPAN + (p mod SPAN); bottom j = i + SPAN.
  - Twiddle index t = (p mod SPAN) * (N/(2*SPAN)).
  - Results overwrite positions i and j of the working bank (in place).
- Twiddle W^t = cos(2πt/N) − j·sin(2πt/N), quantised to FRACTION bits by round-to-nearest (ties away from zero) and saturated to DATA_WIDTH.
- Butterfly arithmetic, with a at i, b at j:
  - prod = b*W as full-precision complex: real = br*wr − bi*wi, imag = br*wi + bi*wr, in 2*DW+1 bits.
  - Round prod by adding 2^(FRACTION−1), then arithmetic shift right by FRACTION.
  - top = a + prod, bot = a − prod, computed in DW+2 bits.
  - If scale_en was latched: x = (x + 1) >>> 1.
  - Saturate each real/imag word to [−2^(DW−1), 2^(DW−1)−1]. Any clamp sets overflow, which stays set until the next input handshake or reset.

Decomposition:
- Package fft_pkg:
  - Complex word type parameterised by DATA_WIDTH.
  - Function sat_round(value, width).
  - Function for the pair/twiddle index mapping.
  - Elaboration-time twiddle generation function.
- Sub-module fft_bfly_unit: one combinational butterfly (complex multiply, round, add/sub, optional scale, saturate, overflow flag). Instantiated NUM_BFLY times.
- The top level holds the FSM, counter, frame register bank and twiddle selection mux.

Test Plan:
- Impulse: element 0 real = 0x10, all else 0, scale_en = 0 → out0 = (0x10, 0), out8 = (0x10, 0), all others 0; out_valid at edge 5 after handshake; overflow = 0.
- Twiddle W^2: element 9 real = 0x10 (W^2 = 0x0F − j·0x06) → out1 = (0x0F, 0xFA), out9 = (0xF1, 0x06).
- Saturation: elements 0 and 8 real = 0x70.
  - scale_en = 0 → out0 real = 0x7F, out8 real = 0x00, overflow = 1.
  - scale_en = 1 → out0 real = 0x70, out8 real = 0x00, overflow = 0.
- Backpressure: hold out_ready = 0 for 10 cycles → out_data/overflow stable, in_ready = 0, a second in_valid is ignored. After the handshake, in_ready = 1 next cycle and the second frame is accepted.
- Reset mid-CALC: assert reset at counter = 2 → next cycle in_ready = 1, out_valid = 0, busy = 0, out_data = 0, overflow = 0; a subsequent frame completes normally.
- Variant N = 16, SPAN = 1, NUM_BFLY = 8: x0 = x1 = 0x10 real → out0 = 0x20, out1 = 0x00; out_valid at edge 2 after handshake.
